// File: rtl/x_load_tx.sv
// Host-side transmitter: buffers one X matrix written by the host and streams it
// into the accelerator's serial load port on go, then waits for finish or a timeout.
module x_load_tx #(
    parameter int DATA_W    = 8,
    parameter int N_ELEM    = 32,
    parameter int START_GAP = 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              go,
    output logic              buf_full,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              start_in,
    output logic [DATA_W-1:0] X_load,
    output logic              valid_input,
    input  logic              finish
);
    localparam int PTR_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int CNT_W = $clog2(N_ELEM + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_ELEM);
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(N_ELEM - 1);
    localparam logic [3:0]       GAP_LAST = (START_GAP > 0) ? 4'(START_GAP - 1) : 4'd0;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_GAP   = 3'd2,
        S_SEND  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [DATA_W-1:0] mem [N_ELEM];
    logic [PTR_W-1:0]  wr_ptr_r, wr_ptr_s, idx_r, idx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [3:0]        gap_r, gap_s;
    logic [TMO_W-1:0]  tmo_r, tmo_s;
    logic              err_r, err_s, done_s, we_s;
    logic              full_r, busy_r, done_r, start_r, valid_r;
    logic [DATA_W-1:0] xload_r, xload_s;

    // Next-state, buffer bookkeeping and error detection.
    always_comb begin
        state_s  = state_r;
        wr_ptr_s = wr_ptr_r;
        cnt_s    = cnt_r;
        idx_s    = idx_r;
        gap_s    = gap_r;
        tmo_s    = tmo_r;
        err_s    = err_r;
        done_s   = 1'b0;
        we_s     = 1'b0;
        xload_s  = '0;

        if (wr_en && (state_r == S_IDLE) && (cnt_r != CNT_FULL)) begin
            we_s     = 1'b1;
            wr_ptr_s = wr_ptr_r + PTR_W'(1);
            cnt_s    = cnt_r + CNT_W'(1);
        end else if (wr_en) begin
            err_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end

        case (state_r)
            // go is judged on the pre-write count even if a write lands this cycle
            S_IDLE: begin
                if (go && (cnt_r == CNT_FULL)) begin
                    state_s = S_START;
                end else if (go) begin
                    err_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                idx_s = '0;
                gap_s = 4'd0;
                if (START_GAP > 0) begin
                    state_s = S_GAP;
                end else begin
                    state_s = S_SEND;
                end
            end
            S_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_s = S_SEND;
                end else begin
                    gap_s = gap_r + 4'd1;
                end
            end
            S_SEND: begin
                if (idx_r == IDX_LAST) begin
                    state_s = S_WAIT;
                    tmo_s   = '0;
                end else begin
                    idx_s = idx_r + PTR_W'(1);
                end
            end
            S_WAIT: begin
                if (finish) begin
                    state_s  = S_IDLE;
                    done_s   = 1'b1;
                    wr_ptr_s = '0;
                    cnt_s    = '0;
                end else if (tmo_r == TMO_LAST) begin
                    state_s  = S_IDLE;
                    err_s    = 1'b1;
                    wr_ptr_s = '0;
                    cnt_s    = '0;
                end else begin
                    tmo_s = tmo_r + TMO_W'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // X_load is presented from a register, so fetch the element for the next cycle
        if (state_s == S_SEND) begin
            xload_s = mem[idx_s];
        end else begin
            xload_s = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            wr_ptr_r <= '0;
            cnt_r    <= '0;
            idx_r    <= '0;
            gap_r    <= 4'd0;
            tmo_r    <= '0;
            err_r    <= 1'b0;
            full_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            start_r  <= 1'b0;
            valid_r  <= 1'b0;
            xload_r  <= '0;
        end else begin
            state_r  <= state_s;
            wr_ptr_r <= wr_ptr_s;
            cnt_r    <= cnt_s;
            idx_r    <= idx_s;
            gap_r    <= gap_s;
            tmo_r    <= tmo_s;
            err_r    <= err_s;
            full_r   <= (cnt_s == CNT_FULL);
            busy_r   <= (state_s != S_IDLE);
            done_r   <= done_s;
            start_r  <= (state_s == S_START);
            valid_r  <= (state_s == S_SEND);
            xload_r  <= xload_s;
        end
    end

    // Element storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[wr_ptr_r] <= wr_data;
        end
    end

    assign buf_full    = full_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign start_in    = start_r;
    assign valid_input = valid_r;
    assign X_load      = xload_r;
endmodule

// File: tb/tb_x_load_tx.sv
// Bench for x_load_tx: randomized buffer contents checked cycle by cycle against a
// trace computed from the transfer timeline (start, gap, send window, wait, end).
module tb_x_load_tx;
    localparam int DW  = 8;
    localparam int N   = 32;
    localparam int G   = 1;
    localparam int TMO = 16;
    localparam int FV  = 2 + G;       // first valid cycle after go
    localparam int LV  = 1 + G + N;   // last valid cycle after go
    localparam int NC  = 56;

    logic          clk = 1'b0;
    logic          rst = 1'b0, wr_en = 1'b0, go = 1'b0, finish = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          buf_full, busy, done, err, start_in, valid_input;
    logic [DW-1:0] X_load;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] q[$];
    bit            mdl_err = 1'b0;
    logic [12:0]   obs [0:NC];
    logic [12:0]   exp_v;

    x_load_tx #(.DATA_W(DW), .N_ELEM(N), .START_GAP(G), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .go(go),
        .buf_full(buf_full), .busy(busy), .done(done), .err(err),
        .start_in(start_in), .X_load(X_load), .valid_input(valid_input),
        .finish(finish)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        q.delete();
        mdl_err = 1'b0;
    endtask

    task automatic fill(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = ramp ? 8'(i + 1) : 8'($urandom);
            if (q.size() < N) q.push_back(wr_data);
            else mdl_err = 1'b1;
            tick();
        end
        wr_en = 1'b0;
    endtask

    // Pulse go in cycle 0 and record outputs for cycles 1..ncyc.
    task automatic capture(input int ncyc, input int fin_a, input int fin_b,
                           input int wr_c, input int go_c, input int rst_c);
        for (int k = 0; k < ncyc; k++) begin
            go      = (k == 0) || (k == go_c);
            finish  = (k == fin_a) || (k == fin_b);
            wr_en   = (k == wr_c);
            wr_data = 8'($urandom);
            rst     = (k == rst_c);
            tick();
            obs[k+1] = {err, busy, done, start_in, valid_input, X_load};
        end
        go = 1'b0; finish = 1'b0; wr_en = 1'b0; rst = 1'b0;
    endtask

    // Expected {err,busy,done,start,valid,X} at cycle k after go.
    function automatic logic [12:0] expect_at(int k, int fin, int rst_c, int wr_c, bit err0);
        int end_c;
        bit v, b, d, s, e;
        logic [DW-1:0] x;
        if (rst_c >= 0 && k > rst_c) return 13'd0;
        end_c = (fin > LV) ? fin + 1 : LV + TMO + 1;
        s = (k == 1);
        v = (k >= FV) && (k <= LV);
        x = v ? q[k-FV] : 8'd0;
        b = (k >= 1) && (k < end_c);
        d = (fin > LV) && (k == fin + 1);
        e = err0 || ((fin <= LV) && (k >= end_c)) || ((wr_c >= 0) && (k > wr_c));
        return {e, b, d, s, v, x};
    endfunction

    task automatic test_reset();
        wr_en = 1'b1; go = 1'b1; finish = 1'b1; wr_data = 8'hA5; rst = 1'b1;
        tick();
        tick();
        rst = 1'b0; wr_en = 1'b0; go = 1'b0; finish = 1'b0;
        q.delete();
        mdl_err = 1'b0;
        n_cmp++; if (start_in !== 1'b0) begin n_bad++; $display("FAIL reset_start got=%b exp=0", start_in); end
        n_cmp++; if (valid_input !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid_input); end
        n_cmp++; if (X_load !== 8'h00) begin n_bad++; $display("FAIL reset_xload got=%h exp=00", X_load); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (buf_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b exp=0", buf_full); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_normal(input bit ramp, input int fin_dly);
        bit e0;
        fill(N, ramp);
        e0 = mdl_err;
        n_cmp++; if (buf_full !== 1'b1) begin n_bad++; $display("FAIL normal_full got=%b exp=1", buf_full); end
        capture(NC, LV + fin_dly, -1, -1, -1, -1);
        for (int k = 1; k <= NC; k++) begin
            exp_v = expect_at(k, LV + fin_dly, -1, -1, e0);
            n_cmp++;
            if (obs[k] !== exp_v) begin
                n_bad++;
                $display("FAIL normal cyc=%0d got=%h exp=%h", k, obs[k], exp_v);
            end
        end
        n_cmp++; if (buf_full !== 1'b0) begin n_bad++; $display("FAIL normal_full_after got=%b exp=0", buf_full); end
        q.delete();
    endtask

    task automatic test_overflow();
        bit e0;
        do_reset();
        fill(N, 1'b0);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ovf_err_before got=%b exp=0", err); end
        fill(1, 1'b0);
        e0 = mdl_err;
        n_cmp++; if (err !== e0) begin n_bad++; $display("FAIL ovf_err got=%b exp=%b", err, e0); end
        n_cmp++; if (buf_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full got=%b exp=1", buf_full); end
        capture(NC, LV + 3, -1, -1, -1, -1);
        for (int k = 1; k <= NC; k++) begin
            exp_v = expect_at(k, LV + 3, -1, -1, e0);
            n_cmp++;
            if (obs[k] !== exp_v) begin
                n_bad++;
                $display("FAIL ovf cyc=%0d got=%h exp=%h", k, obs[k], exp_v);
            end
        end
        q.delete();
    endtask

    task automatic test_early_go();
        do_reset();
        fill(10, 1'b1);
        go = 1'b1;
        tick();
        go = 1'b0;
        n_cmp++; if (start_in !== 1'b0) begin n_bad++; $display("FAIL early_start got=%b exp=0", start_in); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL early_busy got=%b exp=0", busy); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL early_err got=%b exp=1", err); end
        tick();
        n_cmp++; if (start_in !== 1'b0) begin n_bad++; $display("FAIL early_start2 got=%b exp=0", start_in); end
        fill(N - 10, 1'b0);
        n_cmp++; if (buf_full !== 1'b1) begin n_bad++; $display("FAIL early_full got=%b exp=1", buf_full); end
        q.delete();
    endtask

    task automatic test_timeout();
        do_reset();
        fill(N, 1'b0);
        capture(NC, -1, -1, -1, -1, -1);
        for (int k = 1; k <= NC; k++) begin
            exp_v = expect_at(k, -1, -1, -1, 1'b0);
            n_cmp++;
            if (obs[k] !== exp_v) begin
                n_bad++;
                $display("FAIL timeout cyc=%0d got=%h exp=%h", k, obs[k], exp_v);
            end
        end
        n_cmp++; if (buf_full !== 1'b0) begin n_bad++; $display("FAIL timeout_full got=%b exp=0", buf_full); end
        q.delete();
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        fill(N, 1'b0);
        capture(NC, -1, -1, -1, -1, FV + 7);
        for (int k = 1; k <= NC; k++) begin
            exp_v = expect_at(k, -1, FV + 7, -1, 1'b0);
            n_cmp++;
            if (obs[k] !== exp_v) begin
                n_bad++;
                $display("FAIL rst_send cyc=%0d got=%h exp=%h", k, obs[k], exp_v);
            end
        end
        q.delete();
        mdl_err = 1'b0;
        fill(1, 1'b0);
        n_cmp++; if (buf_full !== 1'b0) begin n_bad++; $display("FAIL rst_send_full got=%b exp=0", buf_full); end
        do_reset();
    endtask

    task automatic test_spurious();
        do_reset();
        fill(N, 1'b0);
        capture(NC, FV + 3, LV + 6, LV + 2, 10, -1);
        for (int k = 1; k <= NC; k++) begin
            exp_v = expect_at(k, LV + 6, -1, LV + 2, 1'b0);
            n_cmp++;
            if (obs[k] !== exp_v) begin
                n_bad++;
                $display("FAIL spurious cyc=%0d got=%h exp=%h", k, obs[k], exp_v);
            end
        end
        q.delete();
    endtask

    initial begin
        test_reset();
        test_normal(1'b1, 5);
        test_normal(1'b0, int'($urandom_range(1, 12)));
        test_normal(1'b0, int'($urandom_range(1, 12)));
        test_overflow();
        test_early_go();
        test_timeout();
        test_reset_mid_send();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
